// File: rtl/fu_div_seq_if.sv
// Issue/write-back bus for the sequential divide unit.
interface fu_div_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            EN;
    logic [1:0]      op;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            busy;
    logic            finish;
    logic [XLEN-1:0] res;

    // Issue side: drives a request and watches for the result.
    modport master (
        output EN,
        output op,
        output A,
        output B,
        input  busy,
        input  finish,
        input  res
    );

    // Divide unit side.
    modport slave (
        input  EN,
        input  op,
        input  A,
        input  B,
        output busy,
        output finish,
        output res
    );
endinterface

// File: rtl/fu_div_seq.sv
// Sequential RV32M divide unit: radix-2 restoring, fixed latency EN -> finish.
// op[0]=1 selects unsigned, op[1]=1 selects remainder.
module fu_div_seq #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned LATENCY = 34
) (
    input logic          clk,
    input logic          rst,
    fu_div_seq_if.slave  bus
);
    localparam int unsigned CNT_W     = (XLEN > 1) ? $clog2(XLEN) : 1;
    // One latch cycle and one FIX cycle surround the XLEN restoring steps.
    localparam int unsigned LAST_ITER = LATENCY - 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] rem_acc;
    logic [XLEN-1:0] quo_acc;
    logic [XLEN-1:0] dvsr;
    logic            is_rem;
    logic            neg_q;
    logic            neg_r;
    logic            div_zero;
    logic            ovf;
    logic            busy_r;
    logic            finish_r;
    logic [XLEN-1:0] res_r;

    logic            op_signed_c;
    logic            a_neg_c;
    logic            b_neg_c;
    logic [XLEN-1:0] a_mag_c;
    logic [XLEN-1:0] b_mag_c;
    logic            div_zero_c;
    logic            ovf_c;
    logic [XLEN:0]   shifted_c;
    logic [XLEN:0]   trial_c;
    logic            take_c;
    logic [XLEN-1:0] q_fix_c;
    logic [XLEN-1:0] r_fix_c;
    logic [XLEN-1:0] result_c;

    // Operand decode at issue: sign flags, magnitudes and RV32M special cases.
    always_comb begin
        op_signed_c = ~bus.op[0];
        a_neg_c     = op_signed_c & bus.A[XLEN-1];
        b_neg_c     = op_signed_c & bus.B[XLEN-1];
        a_mag_c     = a_neg_c ? (XLEN'(0) - bus.A) : bus.A;
        b_mag_c     = b_neg_c ? (XLEN'(0) - bus.B) : bus.B;
        div_zero_c  = (bus.B == '0);
        ovf_c       = op_signed_c
                      && (bus.A == {1'b1, {(XLEN-1){1'b0}}})
                      && (bus.B == '1);
    end

    // One restoring step: shift {rem, quo} left, keep trial when it stays non-negative.
    always_comb begin
        shifted_c = {rem_acc, quo_acc[XLEN-1]};
        trial_c   = shifted_c - {1'b0, dvsr};
        take_c    = ~trial_c[XLEN];
    end

    // Sign fix-up and special-case selection for the FIX cycle.
    // A zero divisor leaves |A| in the remainder, so the sign fix already yields A.
    always_comb begin
        q_fix_c = neg_q ? (XLEN'(0) - quo_acc) : quo_acc;
        r_fix_c = neg_r ? (XLEN'(0) - rem_acc) : rem_acc;
        if (is_rem) begin
            result_c = ovf ? '0 : r_fix_c;
        end else if (div_zero) begin
            result_c = '1;
        end else if (ovf) begin
            result_c = {1'b1, {(XLEN-1){1'b0}}};
        end else begin
            result_c = q_fix_c;
        end
    end

    // Control FSM and datapath registers; reset wins over every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rem_acc  <= '0;
            quo_acc  <= '0;
            dvsr     <= '0;
            is_rem   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
            busy_r   <= 1'b0;
            finish_r <= 1'b0;
            res_r    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    finish_r <= 1'b0;
                    if (bus.EN) begin
                        is_rem   <= bus.op[1];
                        neg_q    <= a_neg_c ^ b_neg_c;
                        neg_r    <= a_neg_c;
                        div_zero <= div_zero_c;
                        ovf      <= ovf_c;
                        rem_acc  <= '0;
                        quo_acc  <= a_mag_c;
                        dvsr     <= b_mag_c;
                        cnt      <= '0;
                        busy_r   <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    rem_acc <= take_c ? trial_c[XLEN-1:0] : shifted_c[XLEN-1:0];
                    quo_acc <= {quo_acc[XLEN-2:0], take_c};
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(LAST_ITER)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    res_r    <= result_c;
                    finish_r <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    finish_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    finish_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.finish = finish_r;
    assign bus.res    = res_r;
endmodule

// File: tb/tb_fu_div_seq.sv
// Scoreboard bench for fu_div_seq: directed RV32M vectors, latency and busy checks.
module tb_fu_div_seq;
    localparam int unsigned XLEN = 32;
    localparam int          LAT  = 34;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef struct {
        string           name;
        logic [XLEN-1:0] res;
        int              start;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   tests;
    int   fails;
    exp_t sb[$];
    logic busy_gap;
    logic [XLEN-1:0] last_res;

    fu_div_seq_if #(.XLEN(XLEN)) bus ();

    fu_div_seq #(.XLEN(XLEN), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every finish pulse, checks value, latency and busy.
    initial begin
        busy_gap = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && sb.size() > 0 && cyc > sb[0].start && bus.busy !== 1'b1)
                busy_gap = 1'b1;
            if (bus.finish === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_finish", 32'(bus.finish), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_res"}, bus.res, e.res);
                    check({e.name, "_lat"}, 32'(cyc - e.start), 32'(LAT));
                    check({e.name, "_busy_gap"}, 32'(busy_gap), 32'd0);
                    busy_gap = 1'b0;
                end
            end
        end
    end

    // Wait until the previous divide is retired and the unit is idle; bounded.
    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sb.size() != 0 || bus.busy !== 1'b0) && n < 100);
        if (n >= 100) begin
            check("idle_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // Issue one divide at the current negedge; operands scrambled after the EN cycle.
    task automatic issue(input string name, input logic [1:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_res,
                         input bit push, output int start);
        exp_t e;
        start     = cyc;
        bus.EN    = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        if (push) begin
            e.name  = name;
            e.res   = exp_res;
            e.start = start;
            sb.push_back(e);
            last_res = exp_res;
        end
        @(negedge clk);
        bus.EN = 1'b0;
        bus.op = 2'(~op);
        bus.A  = $urandom;
        bus.B  = $urandom;
    endtask

    task automatic run(input string name, input logic [1:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_res);
        int s;
        wait_idle();
        issue(name, op, a, b, exp_res, 1'b1, s);
    endtask

    initial begin
        int s1;
        int s2;
        tests = 0;
        fails = 0;
        cyc   = 0;
        rst   = 1'b1;
        bus.EN = 1'b0;
        bus.op = 2'b00;
        bus.A  = '0;
        bus.B  = '0;
        last_res = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_finish", 32'(bus.finish), 32'd0);
        check("rst_res", bus.res, 32'd0);
        rst = 1'b0;

        // Basic signed/unsigned results and rounding toward zero.
        run("div_100_7",   OP_DIV,  32'd100,        32'd7,          32'd14);
        run("rem_100_7",   OP_REM,  32'd100,        32'd7,          32'd2);
        run("divu_max_2",  OP_DIVU, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF);
        run("remu_max_2",  OP_REMU, 32'hFFFF_FFFF,  32'd2,          32'd1);
        run("div_m7_2",    OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD);
        run("rem_m7_2",    OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF);
        run("rem_7_m2",    OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1);
        run("div_m100_m7", OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14);

        // Divide by zero.
        run("div_by0",     OP_DIV,  32'd1234,       32'd0,          32'hFFFF_FFFF);
        run("divu_by0",    OP_DIVU, 32'd1234,       32'd0,          32'hFFFF_FFFF);
        run("rem_by0",     OP_REM,  32'd1234,       32'd0,          32'd1234);
        run("remu_by0",    OP_REMU, 32'd1234,       32'd0,          32'd1234);
        run("div_neg_by0", OP_DIV,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF);
        run("rem_neg_by0", OP_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9);

        // Signed overflow.
        run("div_ovf",     OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000);
        run("rem_ovf",     OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0);
        run("divu_min_m1", OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0);

        // EN while busy is ignored; a fresh EN right after DONE is accepted.
        wait_idle();
        issue("divu_50_5", OP_DIVU, 32'd50, 32'd5, 32'd10, 1'b1, s1);
        while (cyc < s1 + 10) @(negedge clk);
        issue("ignored", OP_DIVU, 32'd9, 32'd3, 32'd0, 1'b0, s2);
        wait_idle();
        issue("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b1, s2);
        check("b2b_accept_cycle", 32'(s2 - s1), 32'd35);

        // Result register holds after finish.
        wait_idle();
        repeat (3) @(negedge clk);
        check("res_hold", bus.res, last_res);

        // Reset mid-operation: no finish, state and result cleared.
        issue("div_rst", OP_DIV, 32'd100, 32'd7, 32'd14, 1'b0, s1);
        while (cyc < s1 + 20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_finish", 32'(bus.finish), 32'd0);
        check("midrst_res", bus.res, 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_idle_busy", 32'(bus.busy), 32'd0);

        // Unit still works after reset.
        run("div_after_rst", OP_DIV, 32'd100, 32'd7, 32'd14);
        wait_idle();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fu_div_seq.md
# fu_div_seq

Sequential RV32M divide functional unit. Sits in the FU stage beside the ALU, memory, multiply and jump units: it takes operands from the issue stage and returns quotient or remainder to the write-back register. That register captures `res` while `finish` is high. The unit uses a radix-2 restoring algorithm with a fixed latency, so the control unit can schedule write-back deterministically.

## Interface
Parameters:
- `XLEN`, 32: operand and result width.
- `LATENCY`, 34: cycles from the `EN` cycle to the `finish` cycle. Must equal XLEN+2; other values are not supported.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `EN` input 1: start request, sampled only in IDLE.
- `op` input 2: inst funct3[1:0]; 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `A` input XLEN: dividend (rs1).
- `B` input XLEN: divisor (rs2).
- `busy` output 1: unit occupied, i.e. state is not IDLE.
- `finish` output 1: one-cycle pulse; `res` is valid during this cycle.
- `res` output XLEN: result register.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, with `EN`=1 at the edge:
  - latch `op`, sign flags, |A| and |B| (signed ops) or raw A and B (unsigned ops);
  - clear the remainder accumulator;
  - set iteration counter = 0;
  - go to CALC.
- IDLE, with `EN`=0: stay in IDLE.
- CALC: one restoring step per cycle:
  - shift {rem, quo} left by 1;
  - trial = rem − divisor;
  - if trial is non-negative, rem = trial and quo[0] = 1.
  - After the step with counter = XLEN−1, go to FIX.
- FIX:
  - apply signs: quotient negated if sign(A)≠sign(B) for DIV; remainder negated if sign(A) for REM;
  - apply special cases;
  - write the selected value into `res`;
  - go to DONE.
- DONE: `finish`=1 for exactly this cycle; next edge goes to IDLE.
- Special cases follow RV32M and are resolved in FIX, so latency is unchanged:
  - B=0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give A.
  - DIV with A=0x80000000, B=0xFFFFFFFF gives 0x80000000; the matching REM gives 0.
- `EN` while `busy`=1 is ignored; latched operands and timing are unaffected. The controller must not issue a divide while `busy`.
- `A`, `B` and `op` may change after the `EN` cycle without effect.
- `res` holds its value until the next FIX, so the last result remains readable.

## Timing
- Reset values: state IDLE, `busy`=0, `finish`=0, `res`=0, counter=0, internal accumulators 0.
- `rst` has priority over all other activity: asserting it in any state returns the unit to IDLE on that edge, with no `finish` pulse and `res` cleared.
- Cycle numbering: cycle 0 is the cycle in which `EN`=1 is sampled in IDLE.
  - Cycles 1..32: CALC.
  - Cycle 33: FIX.
  - Cycle 34: DONE, with `finish`=1 and `res` valid.
  - Cycle 35: IDLE; a new `EN` is accepted here.
- `busy`=1 in cycles 1..34.
- `finish` depends only on state (registered state decode), never combinationally on `EN`.
- Back-to-back: `EN` may be asserted in the first IDLE cycle after DONE. Throughput is one divide per 35 cycles.

## Test plan
- Basic signed and unsigned results:
  - DIV A=100, B=7 → `finish` at cycle 34, `res`=14.
  - REM A=100, B=7 → `res`=2.
  - DIVU A=0xFFFFFFFF, B=2 → `res`=0x7FFFFFFF.
- Signed rounding toward zero:
  - DIV A=−7 (0xFFFFFFF9), B=2 → 0xFFFFFFFD.
  - REM same operands → 0xFFFFFFFF.
  - REM A=7, B=−2 → 1.
- Divide by zero:
  - DIV/DIVU A=1234, B=0 → 0xFFFFFFFF.
  - REM/REMU A=1234, B=0 → 1234.
  - All four keep latency 34.
- Signed overflow: DIV A=0x80000000, B=0xFFFFFFFF → 0x80000000; REM → 0.
- `EN` during busy: start DIVU 50/5, re-pulse `EN` with 9/3 at cycle 10 → single `finish` at cycle 34 with `res`=10, `busy` continuous. Fresh `EN` at cycle 35 with 9/3 → `res`=3 at cycle 69.
- Reset mid-operation: start DIV 100/7, assert `rst` at cycle 20 → next cycle IDLE, `busy`=0, `res`=0, no `finish` pulse.
